// File: rtl/md_pkg.sv
// md_pkg: opcode and state encodings shared by the multiply/divide unit, decoder and stall logic
package md_pkg;
  localparam logic [3:0] NONE  = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MTHI  = 4'd5;
  localparam logic [3:0] MTLO  = 4'd6;
  localparam logic [3:0] MFHI  = 4'd7;
  localparam logic [3:0] MFLO  = 4'd8;
  localparam logic [3:0] MADD  = 4'd9;
  localparam logic [3:0] MADDU = 4'd10;
  localparam logic [3:0] MSUB  = 4'd11;
  localparam logic [3:0] MSUBU = 4'd12;
  typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/md_unit_param.sv
// md_unit_param: parametrised multiply/divide/accumulate unit with counter-modelled latency
module md_unit_param
  import md_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic             start,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             req,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);
  localparam int W2 = 2 * WIDTH;
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [W2-1:0]     pend;
  logic [W2-1:0]     acc;
  logic [W2-1:0]     prod_s;
  logic [W2-1:0]     prod_u;
  logic [W2-1:0]     prod;
  logic [W2-1:0]     mul_res;
  logic [W2-1:0]     div_res;
  logic [W2-1:0]     res;
  logic [WIDTH-1:0]  dsor;
  logic [WIDTH-1:0]  q_u;
  logic [WIDTH-1:0]  r_u;
  logic [WIDTH-1:0]  q_s;
  logic [WIDTH-1:0]  r_s;
  logic              is_mul;
  logic              is_div;
  logic              is_sgn;
  logic              b_zero;
  logic              ovf;
  logic              go;
  assign acc     = {hi, lo};
  assign is_mul  = op inside {MULT, MULTU, MADD, MADDU, MSUB, MSUBU};
  assign is_div  = op inside {DIV, DIVU};
  assign is_sgn  = op inside {MULT, MADD, MSUB};
  assign prod_s  = $signed({{WIDTH{src_a[WIDTH-1]}}, src_a}) * $signed({{WIDTH{src_b[WIDTH-1]}}, src_b});
  assign prod_u  = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
  assign prod    = is_sgn ? prod_s : prod_u;
  assign mul_res = (op == MULT || op == MULTU) ? prod :
                   (op == MADD || op == MADDU) ? acc + prod : acc - prod;
  assign b_zero  = src_b == '0;
  assign ovf     = op == DIV && src_a == {1'b1, {(WIDTH-1){1'b0}}} && src_b == '1;
  assign dsor    = (b_zero || ovf) ? WIDTH'(1) : src_b;
  assign q_u     = src_a / dsor;
  assign r_u     = src_a % dsor;
  assign q_s     = $signed(src_a) / $signed(dsor);
  assign r_s     = $signed(src_a) % $signed(dsor);
  assign div_res = b_zero ? {src_a, {WIDTH{1'b1}}} :
                   op == DIVU ? {r_u, q_u} :
                   ovf ? {{WIDTH{1'b0}}, src_a} : {r_s, q_s};
  assign res     = is_div ? div_res : mul_res;
  assign go      = start && !req && state == IDLE;
  assign rd_data = op == MFHI ? hi : op == MFLO ? lo : '0;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      pend  <= '0;
    end else if (go && (is_mul || is_div)) begin
      state <= BUSY;
      busy  <= 1'b1;
      pend  <= res;
      cnt   <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
    end else if (go && op == MTHI) begin
      hi <= src_a;
    end else if (go && op == MTLO) begin
      lo <= src_a;
    end else if (state == BUSY) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        state    <= IDLE;
        busy     <= 1'b0;
        {hi, lo} <= pend;
      end
    end
endmodule

// File: tb/tb_md_unit_param.sv
// tb_md_unit_param: table-driven scoreboard bench for md_unit_param at 32 and 16 bit widths
module tb_md_unit_param;
  import md_pkg::*;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] base_hi;
    logic [31:0] base_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  op = NONE;
  logic        start = 1'b0;
  logic        req = 1'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;
  logic [3:0]  op2 = NONE;
  logic        start2 = 1'b0;
  logic        req2 = 1'b0;
  logic [15:0] a2 = '0;
  logic [15:0] b2 = '0;
  logic        busy2;
  logic [15:0] hi2;
  logic [15:0] lo2;
  logic [15:0] rd2;
  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        sb[$];
  vec_t        vecs[12];
  always #5 clk = ~clk;
  md_unit_param dut (
    .clk(clk), .reset(reset), .op(op), .start(start), .src_a(src_a), .src_b(src_b),
    .req(req), .busy(busy), .hi(hi), .lo(lo), .rd_data(rd_data)
  );
  md_unit_param #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3), .CNT_W(4)) dut16 (
    .clk(clk), .reset(reset), .op(op2), .start(start2), .src_a(a2), .src_b(b2),
    .req(req2), .busy(busy2), .hi(hi2), .lo(lo2), .rd_data(rd2)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic r);
    @(negedge clk);
    op = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    req = r;
    @(posedge clk);
    #1;
    start = 1'b0;
    req = 1'b0;
    op = NONE;
  endtask
  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    drive(MTHI, h, 32'h0, 1'b0);
    drive(MTLO, l, 32'h0, 1'b0);
  endtask
  task automatic wait_done(input string name, input int pulse_req_at);
    int   n;
    exp_t e;
    n = 0;
    while (busy && n < 64) begin
      n++;
      if (n == pulse_req_at) begin
        @(negedge clk);
        req = 1'b1;
      end
      @(posedge clk);
      #1;
      req = 1'b0;
    end
    if (sb.size() == 0) begin
      chk({name, "_scoreboard_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({name, "_busy_cycles"}, 64'(n), 64'(e.cyc));
      chk({name, "_hi"}, 64'(hi), 64'(e.hi));
      chk({name, "_lo"}, 64'(lo), 64'(e.lo));
      @(negedge clk);
      op = MFHI;
      #1 chk({name, "_mfhi"}, 64'(rd_data), 64'(e.hi));
      op = MFLO;
      #1 chk({name, "_mflo"}, 64'(rd_data), 64'(e.lo));
      op = NONE;
    end
  endtask
  initial begin
    int n;
    vecs[0]  = '{MULT,  32'hFFFFFFFE, 32'd3,        32'h0, 32'h0,  32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{MADDU, 32'hFFFFFFFF, 32'd2,        32'h0, 32'd10, 32'h00000002, 32'h00000008, 5};
    vecs[2]  = '{MSUBU, 32'd1,        32'd2,        32'h0, 32'd10, 32'h00000000, 32'h00000008, 5};
    vecs[3]  = '{DIV,   32'hFFFFFFF9, 32'd2,        32'h0, 32'h0,  32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4]  = '{DIVU,  32'h00001234, 32'd0,        32'h0, 32'h0,  32'h00001234, 32'hFFFFFFFF, 10};
    vecs[5]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0,  32'h00000000, 32'h80000000, 10};
    vecs[6]  = '{MADD,  32'hFFFFFFFD, 32'd4,        32'h0, 32'd5,  32'hFFFFFFFF, 32'hFFFFFFF9, 5};
    vecs[7]  = '{MSUB,  32'hFFFFFFFD, 32'hFFFFFFFD, 32'h0, 32'h0,  32'hFFFFFFFF, 32'hFFFFFFF7, 5};
    vecs[8]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7, 32'h7,  32'hFFFFFFFE, 32'h00000001, 5};
    vecs[9]  = '{DIVU,  32'd100,      32'd7,        32'h0, 32'h0,  32'h00000002, 32'h0000000E, 10};
    vecs[10] = '{DIV,   32'd7,        32'hFFFFFFFE, 32'h0, 32'h0,  32'h00000001, 32'hFFFFFFFD, 10};
    vecs[11] = '{DIV,   32'hFFFFFFFB, 32'd0,        32'h0, 32'h0,  32'hFFFFFFFB, 32'hFFFFFFFF, 10};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy16", 64'(busy2), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      set_hilo(vecs[i].base_hi, vecs[i].base_lo);
      chk($sformatf("v%0d_base", i), {hi, lo}, {vecs[i].base_hi, vecs[i].base_lo});
      sb.push_back('{vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].cyc});
      drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      wait_done($sformatf("v%0d", i), 0);
    end
    set_hilo(32'h11, 32'h22);
    drive(MULT, 32'd5, 32'd7, 1'b1);
    chk("req_mult_busy", 64'(busy), 64'd0);
    chk("req_mult_hilo", {hi, lo}, {32'h11, 32'h22});
    drive(MTLO, 32'h99, 32'h0, 1'b1);
    chk("req_mtlo_lo", 64'(lo), 64'h22);
    drive(4'd13, 32'd5, 32'd7, 1'b0);
    chk("bad_op_busy", 64'(busy), 64'd0);
    chk("bad_op_hilo", {hi, lo}, {32'h11, 32'h22});
    @(negedge clk);
    op = MFHI;
    #1 chk("mfhi_nostart", 64'(rd_data), 64'h11);
    op = NONE;
    #1 chk("rd_none", 64'(rd_data), 64'h0);
    sb.push_back('{32'h2, 32'hE, 10});
    drive(DIVU, 32'd100, 32'd7, 1'b0);
    wait_done("div_req_pulse", 3);
    set_hilo(32'h55, 32'h66);
    drive(MULT, 32'd5, 32'd7, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_late_busy", 64'(busy), 64'd0);
    chk("midrst_late_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    op2 = MULTU;
    a2 = 16'hFFFF;
    b2 = 16'hFFFF;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    n = 0;
    while (busy2 && n < 20) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("w16_mul_cycles", 64'(n), 64'd1);
    chk("w16_mul_hilo", {hi2, lo2}, 32'hFFFE0001);
    @(negedge clk);
    op2 = DIVU;
    a2 = 16'd100;
    b2 = 16'd7;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    op2 = MULTU;
    a2 = 16'd2;
    b2 = 16'd3;
    n = 0;
    while (busy2 && n < 20) begin
      n++;
      @(posedge clk);
      #1;
    end
    start2 = 1'b0;
    op2 = NONE;
    chk("w16_div_cycles", 64'(n), 64'd3);
    chk("w16_div_hilo", {hi2, lo2}, 32'h0002000E);
    @(posedge clk);
    #1;
    chk("w16_after_busy", 64'(busy2), 64'd0);
    chk("w16_after_hilo", {hi2, lo2}, 32'h0002000E);
    op2 = MFLO;
    #1 chk("w16_mflo", 64'(rd2), 64'hE);
    op2 = NONE;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
